delay_ram_arbiter: RTL
======================

Name: delay_ram_arbiter

Overview:
- Round-robin arbiter that shares one smart_ram delay line among NUM_CLIENTS effect blocks (echo/chorus/reverb taps).
- Accepts level requests from clients and serialises them into single-cycle wr/rd strobes toward smart_ram.
- Waits for the matching finish pulse, then returns a one-cycle ack plus read data to the granted client.
- Includes a watchdog so that a hung RAM transaction cannot stall the audio pipeline.

Parameters:
- NUM_CLIENTS, 4, number of requesters; at least 2.
- ADDR_WIDTH, 13, delay-line offset width; matches smart_ram.
- DATA_WIDTH, 16, sample width.
- TIMEOUT, 15, maximum WAIT cycles before abort; at least 8.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- cli_req  in  NUM_CLIENTS  per-client request level; held until ack.
- cli_we  in  NUM_CLIENTS  per-client op select: 1=write, 0=read.
- cli_offset  in  NUM_CLIENTS*ADDR_WIDTH  per-client offset; client i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- cli_wdata  in  NUM_CLIENTS*DATA_WIDTH  per-client write sample, packed the same way.
- cli_ack  out  NUM_CLIENTS  one-hot, one-cycle completion pulse.
- cli_rdata  out  DATA_WIDTH  read result; valid in the ack cycle, held until the next read completes.
- err  out  1  high in the ack cycle only when the transaction timed out.
- busy  out  1  high whenever state != IDLE.
- ram_wr  out  1  write strobe to smart_ram.
- ram_rd  out  1  read strobe to smart_ram.
- ram_offset  out  ADDR_WIDTH  offset to smart_ram.
- ram_data_in  out  DATA_WIDTH  write data to smart_ram.
- ram_data_out  in  DATA_WIDTH  smart_ram read data.
- ram_write_finish  in  1  smart_ram write completion pulse.
- ram_read_finish  in  1  smart_ram read completion pulse.
- ram_available  in  1  smart_ram idle indicator.

Behaviour:
- Registering: all outputs are registered.
- Reset (rst=0 at a clk edge):
  - state=IDLE; all strobes, acks, err, busy, timer, cli_rdata, ram_offset and ram_data_in = 0.
  - last_grant=NUM_CLIENTS-1, so client 0 has first priority.
  - Reset mid-transaction aborts it silently: no ack, strobes dropped next edge. A RAM finish pulse that arrives after reset is ignored because the FSM is in IDLE.
- FSM IDLE:
  - Leaves IDLE only if ram_available=1 and some cli_req bit is 1.
  - Winner is the first requesting index searching upward from last_grant+1, modulo NUM_CLIENTS.
  - Latches winner index, cli_we, offset and wdata into ram_offset and ram_data_in; next state ISSUE.
- FSM ISSUE: exactly one cycle of ram_wr=1 (write) or ram_rd=1 (read); never both. Timer cleared; next state WAIT.
- FSM WAIT:
  - Strobes are 0. The finish signal of the other op type is ignored.
  - Write completes on ram_write_finish; read completes on ram_read_finish and latches ram_data_out into cli_rdata. Next state ACK.
  - Timer increments each WAIT cycle. If TIMEOUT cycles elapse with no matching finish, go to ACK with err=1; cli_rdata is unchanged.
  - A finish pulse that coincides with the timeout cycle counts as success (err=0).
- FSM ACK:
  - cli_ack[winner]=1 for this cycle only; err is valid this cycle.
  - last_grant=winner; next state IDLE.
  - Requests are not sampled during ACK.
- Client rules:
  - Client holds req/we/offset/wdata stable from assertion until it sees ack, then drops req on the next edge.
  - Because IDLE samples one cycle after ACK, a correctly behaving client is never double-served. A client that keeps req high is re-served only after all other requesters.
- Offset semantics: forwarded unchanged. A write with offset 0 advances the smart_ram write pointer; clients use this for the per-sample input write.
- Latency with smart_ram, counting from the IDLE cycle that samples req:
  - Write: ack at cycle +5.
  - Read: ack at cycle +7.
  - Throughput: one transaction per latency + 1 cycle; no pipelining.
- Simultaneous requests: strict round-robin, giving each requester at most one grant per NUM_CLIENTS grants under full load.

Test Plan:
- Single write: client0 requests we=1, offset=0, wdata=0x1234 -> ram_wr high exactly 1 cycle with ram_data_in=0x1234; cli_ack=4'b0001 at cycle +5; err=0.
- Single read: client2 requests we=0, offset=100 after writes of 0x0001..0x0080 -> ram_rd 1 cycle with ram_offset=100; ack=4'b0100 at cycle +7; cli_rdata equals the sample written 101 writes earlier per smart_ram addressing.
- Contention: all 4 requesting reads continuously from reset -> grant order 0,1,2,3,0,1; exactly one ack bit high per ack cycle; ram_rd/ram_wr never both high.
- Timeout: RAM model never pulses finish -> ack with err=1 after 15 WAIT cycles; cli_rdata unchanged; next request served normally.
- Reset mid-read: assert rst=0 during WAIT -> no ack, state IDLE, all outputs 0 next edge; the late ram_read_finish causes no ack.
- Availability gating: ram_available=0 with req pending -> no strobe issued until ram_available=1, then ISSUE on the following cycle.

Source files
------------

// File: rtl/delay_ram_arbiter.sv
// delay_ram_arbiter: round-robin sharing of one smart_ram delay line
// among effect taps, with a watchdog on every RAM transaction.

module delay_ram_arbiter #(
   parameter int NUM_CLIENTS = 4,
   parameter int ADDR_WIDTH  = 13,
   parameter int DATA_WIDTH  = 16,
   parameter int TIMEOUT     = 15
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_CLIENTS-1:0]            cli_req,
   input  logic [NUM_CLIENTS-1:0]            cli_we,
   input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cli_offset,
   input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cli_wdata,
   output logic [NUM_CLIENTS-1:0]            cli_ack,
   output logic [DATA_WIDTH-1:0]             cli_rdata,
   output logic                              err,
   output logic                              busy,
   output logic                              ram_wr,
   output logic                              ram_rd,
   output logic [ADDR_WIDTH-1:0]             ram_offset,
   output logic [DATA_WIDTH-1:0]             ram_data_in,
   input  logic [DATA_WIDTH-1:0]             ram_data_out,
   input  logic                              ram_write_finish,
   input  logic                              ram_read_finish,
   input  logic                              ram_available
);

   localparam int IW = $clog2(NUM_CLIENTS);
   localparam int TW = $clog2(TIMEOUT);

   localparam logic [NUM_CLIENTS-1:0] ACK_ONE   = NUM_CLIENTS'(1);
   localparam logic [IW-1:0]          LAST_IDX  = IW'(NUM_CLIENTS - 1);
   localparam logic [TW-1:0]          TIMER_END = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      ACK
   } state_t;

   state_t                 state;
   logic [IW-1:0]          last_grant;
   logic [IW-1:0]          winner;
   logic                   win_we;
   logic [TW-1:0]          timer;

   logic                   found;
   logic [IW-1:0]          pick;
   logic                   sel_we;
   logic [ADDR_WIDTH-1:0]  sel_off;
   logic [DATA_WIDTH-1:0]  sel_wd;

   // Round-robin pick: indices above last_grant first, then wrap to 0.
   always_comb begin
      found   = 1'b0;
      pick    = '0;
      sel_we  = 1'b0;
      sel_off = '0;
      sel_wd  = '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         if (!found && cli_req[i] && IW'(i) > last_grant) begin
            found   = 1'b1;
            pick    = IW'(i);
            sel_we  = cli_we[i];
            sel_off = cli_offset[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wd  = cli_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         if (!found && cli_req[i] && IW'(i) <= last_grant) begin
            found   = 1'b1;
            pick    = IW'(i);
            sel_we  = cli_we[i];
            sel_off = cli_offset[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wd  = cli_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Transaction FSM: grant, one-cycle strobe, wait or time out, ack.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         last_grant  <= LAST_IDX;
         winner      <= '0;
         win_we      <= 1'b0;
         timer       <= '0;
         cli_ack     <= '0;
         cli_rdata   <= '0;
         err         <= 1'b0;
         busy        <= 1'b0;
         ram_wr      <= 1'b0;
         ram_rd      <= 1'b0;
         ram_offset  <= '0;
         ram_data_in <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (ram_available && found) begin
                  winner      <= pick;
                  win_we      <= sel_we;
                  ram_offset  <= sel_off;
                  ram_data_in <= sel_wd;
                  ram_wr      <= sel_we;
                  ram_rd      <= !sel_we;
                  busy        <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               ram_wr <= 1'b0;
               ram_rd <= 1'b0;
               timer  <= '0;
               state  <= WAIT;
            end
            WAIT: begin
               if (win_we ? ram_write_finish : ram_read_finish) begin
                  if (!win_we) begin
                     cli_rdata <= ram_data_out;
                  end
                  cli_ack <= ACK_ONE << winner;
                  err     <= 1'b0;
                  state   <= ACK;
               end else if (timer == TIMER_END) begin
                  cli_ack <= ACK_ONE << winner;
                  err     <= 1'b1;
                  state   <= ACK;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            ACK: begin
               cli_ack    <= '0;
               err        <= 1'b0;
               busy       <= 1'b0;
               last_grant <= winner;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
